// File: rtl/cnt_display.sv
// cnt_display: converts an 8-bit binary count to three BCD digits and
// drives a multiplexed 3-digit common-anode 7-segment display.
//
// The count comes from a slow divided-clock domain. It is synchronised here
// and converted only when a new stable value is seen. The conversion is an
// iterative shift-add-3 (double-dabble) that takes 8 shift cycles.
//
// Ports:
//   clk      in   system clock, rising edge
//   Reset    in   synchronous active-high reset
//   CNT      in   [7:0] binary count, asynchronous to clk
//   bcd      out  [11:0] {hundreds, tens, ones}, registered
//   busy     out  high while a conversion is in progress
//   seg      out  [6:0] segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   dig_sel  out  [2:0] active-low digit enable (bit0 ones .. bit2 hundreds)
//
// FSM states:
//   state   | meaning
//   IDLE    | waiting for a stable CNT that differs from the last converted one
//   SHIFT   | one add-3 / shift-left step per cycle, 8 steps
//   DONE    | publish the BCD result
module cnt_display #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [7:0]  CNT,
  output logic [11:0] bcd,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [2:0]  dig_sel
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [6:0]    SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [7:0]    s1_q, s1_d, s2_q, s2_d;
  logic [7:0]    last_bin_q, last_bin_d;
  logic [1:0]    state_q, state_d;
  logic [19:0]   sr_q, sr_d, sr_adj;
  logic [2:0]    it_q, it_d;
  logic [11:0]   bcd_q, bcd_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    dig_sel_q, dig_sel_d;
  logic          start;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  always_comb begin
    s1_d = CNT;
    s2_d = s1_q;
  end

  // Only a value seen identically in both sync stages counts as stable.
  assign start = (s2_q == s1_q) && (s2_q != last_bin_q);

  // Nibbles never exceed 9 before the add, so 4-bit add-3 cannot carry.
  always_comb begin
    sr_adj = sr_q;
    if (sr_q[11:8]  >= 4'd5) sr_adj[11:8]  = sr_q[11:8]  + 4'd3;
    if (sr_q[15:12] >= 4'd5) sr_adj[15:12] = sr_q[15:12] + 4'd3;
    if (sr_q[19:16] >= 4'd5) sr_adj[19:16] = sr_q[19:16] + 4'd3;
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    it_d       = it_q;
    last_bin_d = last_bin_q;
    bcd_d      = bcd_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d       = {12'h000, s2_q};
          last_bin_d = s2_q;
          it_d       = 3'd0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d = sr_adj << 1;
        it_d = it_q + 3'd1;
        if (it_q == 3'd7) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = sr_q[19:8];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = (idx_q >= 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    if (idx_q == 2'd3) idx_d = 2'd0;
  end

  // Output stage follows the current index, so seg and dig_sel stay aligned.
  always_comb begin
    logic [6:0] raw;
    raw       = 7'h00;
    dig_sel_d = 3'b111;
    case (idx_q)
      2'd0: begin
        dig_sel_d = 3'b110;
        raw       = seg_decode(bcd_q[3:0]);
      end
      2'd1: begin
        dig_sel_d = 3'b101;
        raw       = (bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0) ? 7'h00
                                                                 : seg_decode(bcd_q[7:4]);
      end
      2'd2: begin
        dig_sel_d = 3'b011;
        raw       = (bcd_q[11:8] == 4'd0) ? 7'h00 : seg_decode(bcd_q[11:8]);
      end
      default: begin
        dig_sel_d = 3'b111;
        raw       = 7'h00;
      end
    endcase
    seg_d = SEG_ACTIVE_LOW ? ~raw : raw;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      s1_q       <= 8'h00;
      s2_q       <= 8'h00;
      last_bin_q <= 8'h00;
      state_q    <= S_IDLE;
      sr_q       <= 20'h0;
      it_q       <= 3'd0;
      bcd_q      <= 12'h000;
      busy_q     <= 1'b0;
      presc_q    <= '0;
      idx_q      <= 2'd0;
      seg_q      <= SEG_OFF;
      dig_sel_q  <= 3'b111;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      last_bin_q <= last_bin_d;
      state_q    <= state_d;
      sr_q       <= sr_d;
      it_q       <= it_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dig_sel_q  <= dig_sel_d;
    end
  end

  assign bcd     = bcd_q;
  assign busy    = busy_q;
  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;

endmodule

// File: doc/cnt_display.md
Name: cnt_display

Overview:
- Downstream consumer of the 8-bit counter value CNT.
- Converts CNT to three BCD digits with an iterative shift-add-3 (double-dabble) FSM.
- Drives a multiplexed 3-digit common-anode 7-segment display.
- Runs on the board 50 MHz clock. CNT is produced in the divided 1 Hz domain, so it is synchronised and re-converted only when it changes.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (1 kHz digit rate at 50 MHz); legal range >= 2.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when its bit is 0; 0 = lit when 1.

Ports:
- clk  in  1  system clock (50 MHz); all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- CNT  in  8  binary count from counter; asynchronous to this logic, changes at most once per 1 Hz tick.
- bcd  out  12  converted value {hundreds, tens, ones}, registered.
- busy  out  1  high while a conversion is in progress.
- seg  out  7  segments {g,f,e,d,c,b,a}, bit0 = a, polarity per SEG_ACTIVE_LOW.
- dig_sel  out  3  active-low one-hot digit enable; bit0 = ones, bit1 = tens, bit2 = hundreds.

Behaviour:
- Reset values (Reset high at an edge):
  - bcd = 12'h000, busy = 0.
  - seg = all segments off; dig_sel = 3'b111.
  - FSM = IDLE; sync regs, last_bin, prescaler and digit index = 0.
- Input sync: CNT passes through two flops s1 -> s2 every cycle.
- Start condition (evaluated only in IDLE): s2 == s1 AND s2 != last_bin.
- FSM states and transitions:
  - IDLE: on start, load sr[19:0] = {12'h000, s2}, set last_bin = s2, clear iteration count it = 0, go to SHIFT.
  - SHIFT: first add 3 to each of the three BCD nibbles sr[11:8], sr[15:12], sr[19:16] that is >= 5, then shift the whole register left by 1. Increment it. After the 8th SHIFT cycle (it == 7) go to DONE.
  - DONE: bcd <= sr[19:8], go to IDLE.
- busy = 1 in SHIFT and DONE, 0 in IDLE (registered with state).
- Latency: define E0 as the edge leaving IDLE. bcd updates at E0+9; busy rises at E0 and falls at E0+9. Minimum CNT-change-to-bcd latency is 12 edges.
- CNT changes while busy are not lost. They are compared again on return to IDLE, so bcd always converges to the last stable CNT. No restart mid-conversion.
- Reset mid-conversion aborts it:
  - bcd = 000, last_bin = 0.
  - A nonzero CNT then triggers a fresh conversion; CNT = 0 needs none.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - At terminal count the digit index advances 0 -> 1 -> 2 -> 0 (index 3 is unreachable; if ever reached, return to 0).
- Output register: seg and dig_sel are updated every cycle from the current index and bcd, so they lag the index by one cycle and are always mutually aligned.
  - index 0: dig_sel = 3'b110, ones digit.
  - index 1: dig_sel = 3'b101, tens digit.
  - index 2: dig_sel = 3'b011, hundreds digit.
- Leading-zero blanking:
  - Hundreds blanked when bcd[11:8] == 0.
  - Tens blanked when bcd[11:8] == 0 AND bcd[7:4] == 0.
  - Ones never blanked.
  - A blanked digit drives seg = all off while its dig_sel stays asserted.
- Decode (active-high gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Nibbles A-F decode to all off. When SEG_ACTIVE_LOW = 1, invert.
- Scan does not pause during conversion; bcd changes atomically at the DONE edge.
- Arithmetic: nibble add-3 is 4-bit with no carry out (a nibble is at most 9 before the add). 255 is the maximum input, giving bcd 0x255; no overflow is possible.

Test Plan:
- Reset held 3 cycles with CNT = 8'hA5:
  - During reset: bcd = 000, busy = 0, dig_sel = 111, seg = 7'h7F (active-low off).
  - After release: busy rises 3 edges later; bcd = 12'h165 at E0+9.
- CNT = 255 stable from idle: bcd = 12'h255 exactly 9 edges after busy rises; busy high for exactly 9 cycles.
- SCAN_DIV = 4, CNT = 7: dig_sel cycles 110, 101, 011 with 4 cycles per slot.
  - ones slot: seg = ~7'h07 = 7'h78.
  - tens and hundreds slots: seg = 7'h7F (blanked).
- CNT = 100 then 47 applied 2 cycles after busy rises:
  - First conversion completes with bcd = 12'h100.
  - A second conversion follows immediately, giving bcd = 12'h047.
  - Display shows ones '7' (seg = 7'h78), tens '4' (seg = 7'h19), hundreds blanked.
- Reset asserted during SHIFT with CNT = 200:
  - bcd = 000 and busy = 0 on the reset edge.
  - After release, a full conversion gives bcd = 12'h200.
  - Tens slot shows '0' (seg = 7'h40, not blanked because hundreds is nonzero).
- CNT = 0 after reset: no conversion starts (busy stays 0); display shows '0' on ones only.
